// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: PC/stall, imem request/response, decode handoff, error flag.
// slave = fetch_unit side, master = surrounding pipeline/imem side.
interface fetch_unit_if;
    logic [31:0] pc_i;
    logic        stall_o;
    logic        flush_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        err_o;

    modport slave (
        input  pc_i, flush_i, req_ready_i, rsp_valid_i, rsp_data_i, inst_ready_i,
        output stall_o, req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_pc_o, err_o
    );

    modport master (
        output pc_i, flush_i, req_ready_i, rsp_valid_i, rsp_data_i, inst_ready_i,
        input  stall_o, req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_pc_o, err_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch queue; fetch-to-decode latency = imem latency + 1 (no bypass).
// Backpressure: issue stops (stall_o=1) once buffered + discarded-in-flight reaches DEPTH.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d, disc_q, disc_d;
    logic          err_q, err_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   pc_d    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];

    logic [CW:0]   occ;
    logic [CW:0]   pend;
    logic          issue, pop;
    logic          fill_found;
    logic [PW-1:0] fill_idx;
    logic [CW-1:0] undone_cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign occ              = {1'b0, count_q} + {1'b0, disc_q};
    assign pend             = {1'b0, disc_q} + {1'b0, undone_cnt};
    assign bus.req_valid_o  = !bus.flush_i && (occ < (CW+1)'(DEPTH));
    assign bus.req_addr_o   = {bus.pc_i[31:2], 2'b00};
    assign issue            = bus.req_valid_o && bus.req_ready_i;
    assign bus.stall_o      = !issue;
    assign bus.inst_valid_o = (count_q != '0) && done_q[head_q];
    assign bus.inst_o       = instr_q[head_q];
    assign bus.inst_pc_o    = pc_q[head_q];
    assign pop              = bus.inst_valid_o && bus.inst_ready_i && !bus.flush_i;
    assign bus.err_o        = err_q;

    // Done entries always form a prefix from head, so the first not-done
    // live entry is the one the next in-order response belongs to.
    always_comb begin
        int j;
        j          = 0;
        fill_found = 1'b0;
        fill_idx   = '0;
        undone_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            j = int'(head_q) + i;
            if (j >= DEPTH) j = j - DEPTH;
            if ((i < int'(count_q)) && !done_q[PW'(j)]) begin
                undone_cnt = undone_cnt + CW'(1);
                if (!fill_found) begin
                    fill_found = 1'b1;
                    fill_idx   = PW'(j);
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        disc_d  = disc_q;
        err_d   = err_q;
        done_d  = done_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (bus.flush_i) begin
            // Every unfilled entry becomes a response to throw away.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            done_d  = '0;
            disc_d  = CW'(pend);
            if (bus.rsp_valid_i) begin
                if (pend == '0) err_d = 1'b1;
                else            disc_d = CW'(pend - (CW+1)'(1));
            end
        end else begin
            if (issue) begin
                pc_d[tail_q]   = bus.pc_i;
                done_d[tail_q] = 1'b0;
                tail_d         = ptr_inc(tail_q);
            end
            if (bus.rsp_valid_i) begin
                if (disc_q != '0) begin
                    disc_d = disc_q - CW'(1);
                end else if (fill_found) begin
                    instr_d[fill_idx] = bus.rsp_data_i;
                    done_d[fill_idx]  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (pop) head_d = ptr_inc(head_q);
            count_d = count_q + CW'(issue) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            disc_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            disc_q  <= disc_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=2) with an optional latency-1 imem model.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    logic auto_mem;
    logic pc_auto;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Advance one clock; the imem model answers every accepted request one cycle later.
    task automatic clk_step();
        logic        iss;
        logic [31:0] a;
        iss = rst_n && bus.req_valid_o && bus.req_ready_i;
        a   = bus.req_addr_o;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            bus.rsp_valid_i = iss;
            bus.rsp_data_i  = iss ? (32'hD000_0000 | a) : 32'h0;
        end
        if (pc_auto && iss) bus.pc_i = bus.pc_i + 32'd4;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.flush_i      = 1'b0;
        bus.rsp_valid_i  = 1'b0;
        bus.rsp_data_i   = 32'h0;
        bus.req_ready_i  = 1'b1;
        bus.inst_ready_i = 1'b1;
        bus.pc_i         = 32'h0;
        clk_step();
        clk_step();
        bus.rsp_valid_i  = 1'b0;
        rst_n            = 1'b1;
        settle();
    endtask

    initial begin
        int          k;
        int          first_cyc;
        int          issues;
        logic [31:0] exp_pc [3];
        n_checks = 0;
        n_err    = 0;
        auto_mem = 1'b0;
        pc_auto  = 1'b0;
        exp_pc[0] = 32'h0;
        exp_pc[1] = 32'h4;
        exp_pc[2] = 32'h8;

        // Reset state
        do_reset();
        chk("rst_inst_valid", bus.inst_valid_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_req_valid", bus.req_valid_o, 1'b1);
        chk("rst_stall", bus.stall_o, 1'b0);

        // Streaming with latency-1 imem
        auto_mem = 1'b1;
        pc_auto  = 1'b1;
        k = 0;
        first_cyc = -1;
        for (int c = 0; c < 20 && k < 3; c++) begin
            settle();
            if (bus.req_valid_o) chk("stream_stall", bus.stall_o, 1'b0);
            if (bus.inst_valid_o) begin
                if (first_cyc < 0) first_cyc = c;
                chk("stream_pc", bus.inst_pc_o, exp_pc[k]);
                chk("stream_data", bus.inst_o, 32'hD000_0000 | exp_pc[k]);
                k++;
            end
            clk_step();
        end
        chk("stream_count", k, 3);
        chk("stream_latency", first_cyc, 2);

        // Backpressure: decode stalled
        do_reset();
        bus.inst_ready_i = 1'b0;
        issues = 0;
        for (int c = 0; c < 6; c++) begin
            settle();
            if (bus.req_valid_o && bus.req_ready_i) issues++;
            clk_step();
        end
        settle();
        chk("bp_issues", issues, 2);
        chk("bp_req_valid", bus.req_valid_o, 1'b0);
        chk("bp_stall", bus.stall_o, 1'b1);
        chk("bp_inst_valid", bus.inst_valid_o, 1'b1);
        chk("bp_inst_pc", bus.inst_pc_o, 32'h0);
        clk_step();
        settle();
        chk("bp_hold_data", bus.inst_o, 32'hD000_0000);
        chk("bp_hold_pc", bus.inst_pc_o, 32'h0);
        bus.inst_ready_i = 1'b1;
        settle();
        chk("bp_pop_noissue", bus.req_valid_o, 1'b0);
        clk_step();
        settle();
        chk("bp_resume_valid", bus.req_valid_o, 1'b1);
        chk("bp_resume_addr", bus.req_addr_o, 32'h8);
        chk("bp_second_pc", bus.inst_pc_o, 32'h4);

        // Flush with two requests in flight
        auto_mem = 1'b0;
        pc_auto  = 1'b0;
        do_reset();
        bus.pc_i = 32'h10;
        clk_step();
        bus.pc_i = 32'h14;
        clk_step();
        bus.flush_i = 1'b1;
        bus.pc_i    = 32'h100;
        settle();
        chk("fl_req_blocked", bus.req_valid_o, 1'b0);
        clk_step();
        bus.flush_i     = 1'b0;
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 32'hDEAD_0010;
        settle();
        chk("fl_disc_full", bus.req_valid_o, 1'b0);
        clk_step();
        bus.rsp_data_i  = 32'hDEAD_0014;
        settle();
        chk("fl_reissue", bus.req_valid_o, 1'b1);
        chk("fl_reissue_addr", bus.req_addr_o, 32'h100);
        clk_step();
        bus.pc_i        = 32'h104;
        bus.req_ready_i = 1'b0;
        bus.rsp_data_i  = 32'hCAFE_0100;
        settle();
        chk("fl_no_early", bus.inst_valid_o, 1'b0);
        clk_step();
        bus.rsp_valid_i = 1'b0;
        settle();
        chk("fl_valid", bus.inst_valid_o, 1'b1);
        chk("fl_pc", bus.inst_pc_o, 32'h100);
        chk("fl_data", bus.inst_o, 32'hCAFE_0100);
        chk("fl_err", bus.err_o, 1'b0);

        // Flush coinciding with the first old response
        do_reset();
        bus.pc_i = 32'h10;
        clk_step();
        bus.pc_i = 32'h14;
        clk_step();
        bus.flush_i     = 1'b1;
        bus.pc_i        = 32'h100;
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 32'hDEAD_0010;
        clk_step();
        bus.flush_i     = 1'b0;
        bus.rsp_data_i  = 32'hDEAD_0014;
        settle();
        chk("flr_issue", bus.req_valid_o, 1'b1);
        chk("flr_addr", bus.req_addr_o, 32'h100);
        clk_step();
        bus.req_ready_i = 1'b0;
        bus.rsp_data_i  = 32'hBEEF_0100;
        settle();
        chk("flr_no_early", bus.inst_valid_o, 1'b0);
        clk_step();
        bus.rsp_valid_i = 1'b0;
        settle();
        chk("flr_pc", bus.inst_pc_o, 32'h100);
        chk("flr_data", bus.inst_o, 32'hBEEF_0100);
        chk("flr_valid", bus.inst_valid_o, 1'b1);
        chk("flr_err", bus.err_o, 1'b0);

        // Spurious response sets the sticky error
        do_reset();
        bus.req_ready_i = 1'b0;
        bus.rsp_valid_i = 1'b1;
        bus.rsp_data_i  = 32'h1234_5678;
        clk_step();
        bus.rsp_valid_i = 1'b0;
        settle();
        chk("err_set", bus.err_o, 1'b1);
        chk("err_inst_valid", bus.inst_valid_o, 1'b0);
        clk_step();
        clk_step();
        settle();
        chk("err_sticky", bus.err_o, 1'b1);
        rst_n = 1'b0;
        clk_step();
        settle();
        chk("err_cleared", bus.err_o, 1'b0);

        // Reset mid-stream with a full queue
        auto_mem = 1'b1;
        pc_auto  = 1'b1;
        do_reset();
        bus.inst_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) clk_step();
        settle();
        chk("mr_pre_valid", bus.inst_valid_o, 1'b1);
        rst_n = 1'b0;
        clk_step();
        rst_n = 1'b1;
        settle();
        chk("mr_inst_valid", bus.inst_valid_o, 1'b0);
        chk("mr_err", bus.err_o, 1'b0);
        chk("mr_req_valid", bus.req_valid_o, 1'b1);
        chk("mr_req_addr", bus.req_addr_o, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
